icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped, one-word-per-block instruction cache. It sits between the pipelined datapath's fetch port
//  (imemREN/imemaddr/ihit/imemload) and the memory controller's instruction port (iREN/iaddr/iwait/iload).
//  Hits return the instruction in the request cycle. A miss stalls fetch (ihit=0) while one word is filled
//  from memory; the lookup then retries.
// PARAMETERS
//  SETS      16   number of blocks; power of 2, >=2; IDX_W=log2(SETS)
//  TAG_W     30-IDX_W  derived, not overridable; tag = imemaddr[31:2+IDX_W]
// PORTS
//  CLK       in   1   clock, rising edge
//  nRST      in   1   reset, asynchronous, active-low
//  imemREN   in   1   datapath fetch request
//  imemaddr  in   32  fetch byte address; [1:0] ignored
//  flush     in   1   invalidate all blocks (halt / self-modifying-code path)
//  ihit      out  1   imemload valid this cycle; pipeline advances PC on it
//  imemload  out  32  instruction word
//  iREN      out  1   memory read request
//  iaddr     out  32  memory word address, {addr[31:2],2'b00}
//  iwait     in   1   memory busy; data on iload valid in cycle iwait=0 while iREN=1
//  iload     in   32  memory read data
// BEHAVIOUR
//  Storage: per set, valid(1) + tag(TAG_W) + data(32), all flops. Index = imemaddr[2+IDX_W-1:2].
//  Reset: every valid bit=0, state=IDLE, latched miss addr=0. Outputs at reset: ihit=0, imemload=0,
//   iREN=0, iaddr=0. Reset mid-fill drops iREN asynchronously and writes no block.
//  FSM states: IDLE, FETCH.
//   IDLE: hit = imemREN & valid[idx] & tag match. ihit=hit and imemload=data[idx] are combinational
//    (0 latency). On imemREN & !hit & !flush, latch {imemaddr[31:2],2'b00} as maddr and go to FETCH.
//    ihit=0 in this cycle.
//   FETCH: iREN=1, iaddr=maddr, ihit=0, imemload=0. On iwait=0, write valid=1, tag and data=iload into
//    set maddr's index, then go to IDLE. The retry hits the next cycle.
//    Miss penalty = memory latency + 1 cycle. Datapath address changes during FETCH (branch/jump
//    redirect) are ignored: maddr is filled. A new address then misses normally in IDLE.
//  imemREN=0 in IDLE: ihit=0, no state change, no memory traffic.
//  Conflict: a fill overwrites the resident block regardless of its valid bit. No replacement policy
//   exists (direct-mapped).
//  flush: synchronous, highest priority. All valid bits are cleared at the next edge.
//   In IDLE, ihit is forced to 0 in the flush cycle.
//   In FETCH, the fill is aborted and no block is written, even if iwait=0 in the same cycle.
//   The FSM returns to IDLE and iREN drops the next cycle.
//  Fill and flush in the same cycle: flush wins, so the cache is empty afterwards.
//  Outputs in FETCH come from registered state only. No combinational path from iwait to iREN.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
//   hit_count increments on each cycle with ihit=1.
//   miss_count increments on each IDLE->FETCH transition.
//   Both wrap at 2^32 and are not cleared by flush.
//  ICACHE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1 Cold miss: reset, then imemREN=1, imemaddr=0x00000040, memory latency 3 (iwait=1 x2, then 0,
//    iload=0x8C220004) -> iREN=1 and iaddr=0x40 for 3 cycles, then ihit=1 with imemload=0x8C220004
//    the next cycle.
//  2 Hit-after-fill: after test 1, request 0x40 again -> ihit=1 in the same cycle, iREN stays 0.
//  3 Conflict: fill 0x40 (idx 0), then request 0x80 (same idx, different tag) -> miss and refill.
//    Re-request 0x40 -> misses again.
//  4 Redirect mid-fill: miss on 0x100, change imemaddr to 0x200 during FETCH -> iaddr stays 0x100.
//    Set idx0 then holds tag of 0x100; 0x200 then misses with iaddr=0x200.
//  5 Flush: fill 0x04, 0x08, 0x0C, assert flush 1 cycle -> all three re-request as misses.
//    Flush in FETCH with iwait=0 -> no write, iREN=0 next cycle.
//  6 Reset mid-fill: drop nRST while iREN=1 -> iREN=0 immediately.
//    After release, the previously filled address misses. With ICACHE_STATS_EN, after tests 1-2:
//    hit_count=2, miss_count=1.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped, one-word-per-block instruction cache between fetch and memory.
// Optional ICACHE_STATS_EN adds hit_count/miss_count outputs. Rev 1.0
`default_nettype none

module icache_direct_mapped #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];
  logic [29:0]      maddr_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             lookup_hit;
  logic             start_miss;
  logic             fill_en;
  logic             unused_bits;

  assign idx         = imemaddr[2 +: IDX_W];
  assign req_tag     = imemaddr[31 -: TAG_W];
  assign fill_idx    = maddr_q[0 +: IDX_W];
  assign fill_tag    = maddr_q[29 -: TAG_W];
  assign lookup_hit  = valid_q[idx] && (tag_q[idx] == req_tag);
  assign unused_bits = ^imemaddr[1:0];

  // Flush beats a fill landing in the same cycle.
  assign fill_en = (state_q == FETCH) && !iwait && !flush;

  always_comb begin
    state_d    = state_q;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    start_miss = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !flush) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[idx];
          end else begin
            start_miss = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        // Driven only from registered state so iwait never reaches iREN.
        iREN  = 1'b1;
        iaddr = {maddr_q, 2'b00};
        if (flush || !iwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      maddr_q <= 30'h0;
    end else begin
      state_q <= state_d;
      if (start_miss) begin
        maddr_q <= imemaddr[31:2];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < SETS; i++) begin
      if (fill_en && (fill_idx == IDX_W'(i))) begin
        tag_q[i]  <= fill_tag;
        data_q[i] <= iload;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (ihit) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_miss) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: directed self-checking bench for icache_direct_mapped.
`default_nettype none

module tb_icache_direct_mapped;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        flush = 1'b0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;

  icache_direct_mapped #(.SETS(16)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .flush(flush),
    .ihit(ihit),
    .imemload(imemload),
    .iREN(iREN),
    .iaddr(iaddr),
    .iwait(iwait),
    .iload(iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Miss on addr, serve it after lat cycles, then confirm the retry hits.
  task automatic fill(input string tag, input logic [31:0] addr, input int lat,
                      input logic [31:0] word);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    #1;
    chk({tag, "_miss_ihit"}, {31'h0, ihit}, 32'h0);
    chk({tag, "_miss_iren"}, {31'h0, iREN}, 32'h0);
    tick();
    for (int k = 0; k < lat; k++) begin
      iwait = (k != lat - 1);
      iload = word;
      #1;
      chk({tag, "_fetch_iren"}, {31'h0, iREN}, 32'h1);
      chk({tag, "_fetch_iaddr"}, iaddr, {addr[31:2], 2'b00});
      chk({tag, "_fetch_ihit"}, {31'h0, ihit}, 32'h0);
      tick();
    end
    iwait = 1'b1;
    iload = 32'h0;
    #1;
    chk({tag, "_retry_ihit"}, {31'h0, ihit}, 32'h1);
    chk({tag, "_retry_load"}, imemload, word);
    chk({tag, "_retry_iren"}, {31'h0, iREN}, 32'h0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ihit", {31'h0, ihit}, 32'h0);
    chk("rst_load", imemload, 32'h0);
    chk("rst_iren", {31'h0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    nRST = 1'b1;
    tick();

    // 1: cold miss on 0x40, latency 3
    fill("t1", 32'h0000_0040, 3, 32'h8C22_0004);
    tick();
    // 2: hit after fill, no memory traffic
    chk("t2_ihit", {31'h0, ihit}, 32'h1);
    chk("t2_load", imemload, 32'h8C22_0004);
    chk("t2_iren", {31'h0, iREN}, 32'h0);
    tick();
    imemREN = 1'b0;
    #1;
    chk("idle_noreq_ihit", {31'h0, ihit}, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("stats_hits", hit_count, 32'd2);
    chk("stats_misses", miss_count, 32'd1);
`endif
    tick();
    chk("idle_noreq_iren", {31'h0, iREN}, 32'h0);

    // 3: conflict in set 0
    fill("t3_80", 32'h0000_0080, 2, 32'h2001_0080);
    tick();
    fill("t3_40", 32'h0000_0040, 1, 32'h2001_0040);
    tick();

    // 4: redirect during fetch is ignored
    imemaddr = 32'h0000_0100;
    #1;
    chk("t4_miss", {31'h0, ihit}, 32'h0);
    tick();
    imemaddr = 32'h0000_0200;
    iwait = 1'b1;
    #1;
    chk("t4_iaddr_a", iaddr, 32'h0000_0100);
    tick();
    iwait = 1'b0;
    iload = 32'h2001_0100;
    #1;
    chk("t4_iaddr_b", iaddr, 32'h0000_0100);
    tick();
    iwait = 1'b1;
    imemaddr = 32'h0000_0100;
    #1;
    chk("t4_100_hit", {31'h0, ihit}, 32'h1);
    chk("t4_100_load", imemload, 32'h2001_0100);
    imemaddr = 32'h0000_0200;
    #1;
    chk("t4_200_miss", {31'h0, ihit}, 32'h0);
    tick();
    chk("t4_200_iaddr", iaddr, 32'h0000_0200);
    iwait = 1'b0;
    iload = 32'h2001_0200;
    tick();
    iwait = 1'b1;
    #1;
    chk("t4_200_hit", {31'h0, ihit}, 32'h1);
    chk("t4_200_load", imemload, 32'h2001_0200);
    tick();

    // 5: flush in IDLE
    fill("t5_04", 32'h0000_0004, 1, 32'h0000_1004);
    tick();
    fill("t5_08", 32'h0000_0008, 1, 32'h0000_1008);
    tick();
    fill("t5_0c", 32'h0000_000C, 1, 32'h0000_100C);
    flush = 1'b1;
    #1;
    chk("t5_flush_ihit", {31'h0, ihit}, 32'h0);
    tick();
    flush = 1'b0;
    imemREN = 1'b0;
    tick();
    chk("t5_flush_iren", {31'h0, iREN}, 32'h0);
    for (int a = 1; a <= 3; a++) begin
      imemREN = 1'b1;
      imemaddr = 32'(a * 4);
      #1;
      chk("t5_after_flush_ihit", {31'h0, ihit}, 32'h0);
      imemREN = 1'b0;
      #1;
    end
    tick();

    // 5b: flush during fetch aborts the fill
    imemREN = 1'b1;
    imemaddr = 32'h0000_0004;
    tick();
    iwait = 1'b0;
    iload = 32'hDEAD_BEEF;
    flush = 1'b1;
    #1;
    chk("t5b_iren_fetch", {31'h0, iREN}, 32'h1);
    tick();
    flush = 1'b0;
    iwait = 1'b1;
    imemREN = 1'b0;
    #1;
    chk("t5b_iren_after", {31'h0, iREN}, 32'h0);
    imemREN = 1'b1;
    #1;
    chk("t5b_no_write", {31'h0, ihit}, 32'h0);
    imemREN = 1'b0;
    tick();

    // 6: reset mid-fill
    fill("t6_08", 32'h0000_0008, 1, 32'h0000_2008);
    tick();
    imemaddr = 32'h0000_0004;
    tick();
    chk("t6_iren_before", {31'h0, iREN}, 32'h1);
    #1;
    nRST = 1'b0;
    #1;
    chk("t6_iren_async", {31'h0, iREN}, 32'h0);
    imemREN = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    imemREN = 1'b1;
    imemaddr = 32'h0000_0008;
    #1;
    chk("t6_refill_miss", {31'h0, ihit}, 32'h0);
    imemREN = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
